fetch_ctrl: RTL

Instruction-fetch sequencer that drives the next-PC input of the program-counter register and runs the request/acknowledge handshake to instruction memory. It advances the PC by 4 per accepted instruction, holds it under decode back-pressure, and applies branch/jump redirects and traps. It also discards in-flight fetches that a redirect has made stale. It sits between the PC register, the instruction memory port and the decode stage.

---
 rtl/fetch_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl
// ----------
// Instruction-fetch sequencer. Drives the next-PC input of an external PC
// register, runs the request/acknowledge handshake to instruction memory and
// hands fetched words to decode. The PC advances by 4 per accepted
// instruction, holds under decode back-pressure, and is redirected by
// branches/jumps and traps. A fetch still outstanding when a redirect
// arrives is waited out in KILL and its data dropped.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   pc_i                current PC from the PC register
//   pc_next_o           next PC, loaded into the PC register every cycle
//   imem_req_o          fetch request (level, held until ack)
//   imem_addr_o         word-aligned fetch address
//   imem_ack_i          memory accepted request, imem_rdata_i valid
//   imem_rdata_i        fetched instruction word
//   instr_valid_o       instr_o / instr_pc_o valid to decode
//   instr_o             registered instruction word
//   instr_pc_o          address of instr_o
//   instr_ready_i       decode accepts instr_o this cycle
//   redirect_valid_i    taken branch/jump pulse
//   redirect_target_i   redirect destination (low two bits ignored)
//   trap_i              trap pulse, wins over redirect
module fetch_ctrl #(
    parameter logic [31:0] TRAP_VEC = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_i,
    output logic [31:0] pc_next_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_target_i,
    input  logic        trap_i
);

    typedef enum logic [1:0] {
        BOOT,
        REQ,
        HOLD,
        KILL
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic [31:0] pc_next;
    logic        redirect;
    logic [31:0] redirect_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            addr_q     <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_next     = pc_i;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        redirect    = trap_i | redirect_valid_i;
        redirect_pc = trap_i ? TRAP_VEC : (redirect_target_i & 32'hFFFF_FFFC);

        case (state_q)
            BOOT: state_d = REQ;
            REQ: begin
                if (imem_ack_i) begin
                    // A redirect in the ack cycle makes this word stale:
                    // drop it and stay in REQ to fetch the new target.
                    if (!redirect) begin
                        instr_d    = imem_rdata_i;
                        instr_pc_d = pc_i;
                        pc_next    = pc_i + 32'd4;
                        state_d    = HOLD;
                    end
                end else if (redirect) begin
                    state_d = KILL;
                end
            end
            HOLD: begin
                if (redirect || instr_ready_i) begin
                    state_d = REQ;
                end
            end
            KILL: begin
                if (imem_ack_i) begin
                    state_d = REQ;
                end
            end
            default: state_d = BOOT;
        endcase

        if (redirect) begin
            pc_next = redirect_pc;
        end

        // The fetch address is captured only on entry to (or stay in) REQ,
        // so it tracks the PC in REQ and keeps the stale address in KILL.
        addr_d = (state_d == REQ) ? pc_next : addr_q;
    end

    // pc_next is forced to zero while reset is held so the PC register
    // sees a clean reset value even if a redirect input is floating high.
    assign pc_next_o     = rst_n ? pc_next : 32'd0;
    assign imem_req_o    = (state_q == REQ) || (state_q == KILL);
    assign imem_addr_o   = addr_q;
    assign instr_valid_o = (state_q == HOLD);
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;

endmodule
